// File: rtl/sprite_pkg.sv
// Shared sprite-sheet geometry, colour key, latch states and animation frame origins.
package sprite_pkg;

   localparam int SPR_W   = 23;
   localparam int SPR_H   = 30;
   localparam int SHEET_W = 256;

   localparam logic [7:0] TRANSPARENT = 8'hE3;

   typedef enum logic {
      NO_FRAME = 1'b0,
      LIVE     = 1'b1
   } latch_state_e;

   // Top-left sheet coordinates of each animation frame, consumed by the animation FSMs
   localparam logic [10:0] KOOPA_NEUTRAL_F0_ROW = 11'd90;
   localparam logic [10:0] KOOPA_NEUTRAL_F0_COL = 11'd23;
   localparam logic [10:0] KOOPA_NEUTRAL_F1_ROW = 11'd90;
   localparam logic [10:0] KOOPA_NEUTRAL_F1_COL = 11'd46;

endpackage

// File: rtl/sprite_frame_fetcher_if.sv
// Frame/scan inputs, sheet ROM port and compositor outputs of the sprite fetcher.
interface sprite_frame_fetcher_if #(
   parameter int ADDR_W  = 16,
   parameter int COLOR_W = 8
);
   logic               frame_start;
   logic [10:0]        anim_row;
   logic [10:0]        anim_col;
   logic [9:0]         spr_x;
   logic [9:0]         spr_y;
   logic               flip_h;
   logic               pix_valid;
   logic [9:0]         pix_x;
   logic [9:0]         pix_y;
   logic [ADDR_W-1:0]  rom_addr;
   logic [COLOR_W-1:0] rom_data;
   logic               out_valid;
   logic               out_opaque;
   logic [COLOR_W-1:0] out_color;

   modport master (
      output frame_start, anim_row, anim_col, spr_x, spr_y, flip_h,
      output pix_valid, pix_x, pix_y, rom_data,
      input  rom_addr, out_valid, out_opaque, out_color
   );

   modport slave (
      input  frame_start, anim_row, anim_col, spr_x, spr_y, flip_h,
      input  pix_valid, pix_x, pix_y, rom_data,
      output rom_addr, out_valid, out_opaque, out_color
   );
endinterface

// File: rtl/sprite_hit_calc.sv
// Combinational sprite bounds check and local row/column mapping with optional mirroring.
module sprite_hit_calc
   import sprite_pkg::*;
#(
   parameter int W = SPR_W,
   parameter int H = SPR_H
) (
   input  logic       pix_valid,
   input  logic       live,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic [9:0] spr_x,
   input  logic [9:0] spr_y,
   input  logic       flip_h,
   output logic       hit,
   output logic [9:0] lrow,
   output logic [9:0] lcol
);
   logic [9:0] dx;
   logic [9:0] dy;

   // The explicit >= terms stop a pixel left of / above the sprite wrapping into range
   always_comb begin
      dx   = pix_x - spr_x;
      dy   = pix_y - spr_y;
      hit  = pix_valid & live & (pix_x >= spr_x) & (pix_y >= spr_y)
           & (dx < 10'(W)) & (dy < 10'(H));
      lcol = flip_h ? (10'(W - 1) - dx) : dx;
      lrow = dy;
   end
endmodule

// File: rtl/sprite_frame_fetcher.sv
// Scan position to sprite-sheet ROM address, then keyed colour out; 4-cycle fixed latency.
module sprite_frame_fetcher
   import sprite_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int COLOR_W = 8
) (
   input  logic clk,
   input  logic reset_n,
   sprite_frame_fetcher_if.slave bus
);
   localparam int SHIFT = $clog2(SHEET_W);

   latch_state_e state_q, state_d;

   logic [10:0] row0_q, col0_q;
   logic [9:0]  sx_q, sy_q;
   logic        flip_q;

   logic        hit_c;
   logic [9:0]  lrow_c, lcol_c;

   logic               vld_p1, hit_p1, vld_p2, hit_p2, vld_p3, hit_p3;
   logic [11:0]        row_p1, col_p1;
   logic [ADDR_W-1:0]  rom_addr_p2;
   logic               vld_p4, opaque_p4;
   logic [COLOR_W-1:0] color_p4;
   logic               opaque_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= NO_FRAME;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         NO_FRAME: if (bus.frame_start) state_d = LIVE;
         LIVE:     state_d = LIVE;
         default:  state_d = NO_FRAME;
      endcase
   end

   // Shadows change only at frame_start, so a pixel in that same cycle still sees the old frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row0_q <= '0;
         col0_q <= '0;
         sx_q   <= '0;
         sy_q   <= '0;
         flip_q <= 1'b0;
      end else if (bus.frame_start) begin
         row0_q <= bus.anim_row;
         col0_q <= bus.anim_col;
         sx_q   <= bus.spr_x;
         sy_q   <= bus.spr_y;
         flip_q <= bus.flip_h;
      end
   end

   sprite_hit_calc #(.W(SPR_W), .H(SPR_H)) u_hit (
      .pix_valid (bus.pix_valid),
      .live      (state_q == LIVE),
      .pix_x     (bus.pix_x),
      .pix_y     (bus.pix_y),
      .spr_x     (sx_q),
      .spr_y     (sy_q),
      .flip_h    (flip_q),
      .hit       (hit_c),
      .lrow      (lrow_c),
      .lcol      (lcol_c)
   );

   // Stage 1: hit/flip result and sheet row/col (origin folded in here so it travels with the pixel)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1 <= 1'b0;
         hit_p1 <= 1'b0;
      end else begin
         vld_p1 <= bus.pix_valid;
         hit_p1 <= hit_c;
      end
   end

   always_ff @(posedge clk) begin
      row_p1 <= 12'(row0_q) + 12'(lrow_c);
      col_p1 <= 12'(col0_q) + 12'(lcol_c);
   end

   // Stage 2: ROM address; Stage 3: ROM data register lives in the ROM itself
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr_p2 <= '0;
         vld_p2      <= 1'b0;
         hit_p2      <= 1'b0;
         vld_p3      <= 1'b0;
         hit_p3      <= 1'b0;
      end else begin
         rom_addr_p2 <= ADDR_W'({row_p1, {SHIFT{1'b0}}} + (12 + SHIFT)'(col_p1));
         vld_p2      <= vld_p1;
         hit_p2      <= hit_p1;
         vld_p3      <= vld_p2;
         hit_p3      <= hit_p2;
      end
   end

   assign opaque_c = hit_p3 & (bus.rom_data != COLOR_W'(TRANSPARENT));

   // Stage 4: colour key and output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p4    <= 1'b0;
         opaque_p4 <= 1'b0;
         color_p4  <= '0;
      end else begin
         vld_p4    <= vld_p3;
         opaque_p4 <= opaque_c;
         color_p4  <= opaque_c ? bus.rom_data : '0;
      end
   end

   assign bus.rom_addr   = rom_addr_p2;
   assign bus.out_valid  = vld_p4;
   assign bus.out_opaque = opaque_p4;
   assign bus.out_color  = color_p4;
endmodule

// File: tb/tb_sprite_frame_fetcher.sv
// Scoreboard bench for sprite_frame_fetcher: driver queues expectations, monitor checks outputs.
module tb_sprite_frame_fetcher;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int passed = 0;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic        opaque;
      logic [7:0]  color;
   } exp_t;

   exp_t addr_q[$];
   exp_t out_q[$];

   sprite_frame_fetcher_if #(.ADDR_W(16), .COLOR_W(8)) bus ();

   sprite_frame_fetcher #(.ADDR_W(16), .COLOR_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Sheet ROM: one known transparent texel, everything else colour 1C
   function automatic logic [7:0] rom_fn(input logic [15:0] a);
      return (a == 16'd23320) ? sprite_pkg::TRANSPARENT : 8'h1C;
   endfunction

   always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (addr_q.size() > 0 && addr_q[0].cyc + 2 <= cyc) begin
            e = addr_q.pop_front();
            check("rom_addr", 32'(bus.rom_addr), 32'(e.addr));
         end
         if (out_q.size() > 0 && out_q[0].cyc + 4 <= cyc) begin
            e = out_q.pop_front();
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("out_opaque", 32'(bus.out_opaque), 32'(e.opaque));
            check("out_color", 32'(bus.out_color), 32'(e.color));
         end else if (bus.out_valid) begin
            check("stale_out_valid", 32'(bus.out_valid), 32'd0);
         end
      end
   end

   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic fs,
                      input logic chk, input logic [15:0] addr, input logic op,
                      input logic [7:0] col, input logic push = 1'b1);
      exp_t e;
      bus.pix_valid   = 1'b1;
      bus.pix_x       = x;
      bus.pix_y       = y;
      bus.frame_start = fs;
      e.cyc    = cyc;
      e.addr   = addr;
      e.opaque = op;
      e.color  = col;
      if (push) begin
         if (chk) addr_q.push_back(e);
         out_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.pix_valid   = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic new_frame(input logic [10:0] row, input logic [10:0] col,
                            input logic [9:0] x, input logic [9:0] y, input logic flip);
      bus.anim_row    = row;
      bus.anim_col    = col;
      bus.spr_x       = x;
      bus.spr_y       = y;
      bus.flip_h      = flip;
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.anim_row    = '0;
      bus.anim_col    = '0;
      bus.spr_x       = '0;
      bus.spr_y       = '0;
      bus.flip_h      = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.pix_x       = '0;
      bus.pix_y       = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out_opaque", 32'(bus.out_opaque), 32'd0);
      check("reset_out_color", 32'(bus.out_color), 32'd0);
      reset_n = 1'b1;
      idle(2);

      // NO_FRAME: shadows are 0, so these would hit if LIVE; pix_valid has gaps
      pix(10'd5, 10'd5, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      pix(10'd10, 10'd10, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      idle(2);
      pix(10'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      idle(1);
      pix(10'd20, 10'd3, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      idle(6);

      // Origin and corner addressing
      new_frame(11'd90, 11'd23, 10'd100, 10'd50, 1'b0);
      pix(10'd100, 10'd50, 1'b0, 1'b1, 16'd23063, 1'b1, 8'h1C);
      pix(10'd122, 10'd79, 1'b0, 1'b1, 16'd30509, 1'b1, 8'h1C);

      // Bounds and transparency
      pix(10'd99, 10'd50, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      pix(10'd123, 10'd50, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      pix(10'd100, 10'd80, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      pix(10'd101, 10'd51, 1'b0, 1'b1, 16'd23320, 1'b0, 8'h00);

      // Frame latch: no frame_start, then coincident frame_start, then new origin
      bus.anim_row = 11'd120;
      bus.anim_col = 11'd0;
      pix(10'd100, 10'd50, 1'b0, 1'b1, 16'd23063, 1'b1, 8'h1C);
      pix(10'd100, 10'd50, 1'b1, 1'b1, 16'd23063, 1'b1, 8'h1C);
      pix(10'd100, 10'd50, 1'b0, 1'b1, 16'd30720, 1'b1, 8'h1C);
      idle(6);

      // Flip
      new_frame(11'd90, 11'd23, 10'd100, 10'd50, 1'b1);
      pix(10'd100, 10'd50, 1'b0, 1'b1, 16'd23085, 1'b1, 8'h1C);
      pix(10'd122, 10'd50, 1'b0, 1'b1, 16'd23063, 1'b1, 8'h1C);
      idle(8);

      // Reset with four pixels in flight
      pix(10'd100, 10'd50, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0);
      pix(10'd101, 10'd50, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0);
      pix(10'd102, 10'd50, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0);
      pix(10'd103, 10'd50, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0);
      reset_n = 1'b0;
      #1;
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_out_opaque", 32'(bus.out_opaque), 32'd0);
      check("flush_out_color", 32'(bus.out_color), 32'd0);
      check("flush_rom_addr", 32'(bus.rom_addr), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(8);

      // Back in NO_FRAME after reset: former hit position now misses
      pix(10'd100, 10'd50, 1'b0, 1'b0, 16'd0, 1'b0, 8'h00);
      idle(2);

      for (int i = 0; i < 20 && (out_q.size() + addr_q.size()) > 0; i++) begin
         @(posedge clk); #1;
      end
      if ((out_q.size() + addr_q.size()) > 0)
         check("drain_pending", 32'(out_q.size() + addr_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
